dmem_periph_responder: RTL

- Memory-stage data responder for the 5-stage pipelined MIPS CPU.
- Serves the load/store requests presented by the EX/MEM pipeline register: word RAM plus a memory-mapped timer, LED port, switch port and systick counter.
- Read data is returned combinationally, so the MEM/WB register captures it on the same edge that ends the MEM stage.
- Raises the timer interrupt request consumed by the exception/PC-select logic.

---
 rtl/dmem_periph_responder_pkg.sv | 24 ++
 rtl/dmem_timer.sv | 66 ++++++
 rtl/dmem_periph_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmem_periph_responder_pkg.sv
// Shared constants for the MEM-stage data responder: peripheral map and timer control bits.
package dmem_periph_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TCON_W = 3;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned SW_W   = 8;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h4000_0000;

  // Byte offsets inside the peripheral window
  localparam logic [5:0] OFF_TH      = 6'h00;
  localparam logic [5:0] OFF_TL      = 6'h04;
  localparam logic [5:0] OFF_TCON    = 6'h08;
  localparam logic [5:0] OFF_LED     = 6'h0C;
  localparam logic [5:0] OFF_SWITCH  = 6'h10;
  localparam logic [5:0] OFF_SYSTICK = 6'h14;

  // TCON bit positions
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

endpackage

// File: rtl/dmem_timer.sv
// Reloading up-counter timer (TH/TL/TCON) with registered interrupt request.
module dmem_timer
  import dmem_periph_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              th_we,
  input  logic              tl_we,
  input  logic              tcon_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] th,
  output logic [DATA_W-1:0] tl,
  output logic [TCON_W-1:0] tcon,
  output logic              irq
);

  logic [DATA_W-1:0] th_q, th_d;
  logic [DATA_W-1:0] tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;

  // Next state: timer tick first, then CPU writes override TL/TCON wholesale
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (th_we) begin
      th_d = wdata;
    end
    if (tcon_q[TCON_EN]) begin
      if (tl_q == {DATA_W{1'b1}}) begin
        // Reload uses the TH value from before any same-cycle TH write
        tl_d            = th_q;
        tcon_d[TCON_IS] = tcon_q[TCON_IS] | tcon_q[TCON_IE];
      end else begin
        tl_d = tl_q + DATA_W'(1);
      end
    end
    // A TL write cancels the whole overflow event, status included
    if (tl_we) begin
      tl_d            = wdata;
      tcon_d[TCON_IS] = tcon_q[TCON_IS];
    end
    if (tcon_we) begin
      tcon_d = wdata[TCON_W-1:0];
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = tcon_q[TCON_IS];

endmodule

// File: rtl/dmem_periph_responder.sv
// MEM-stage data responder: word RAM plus timer, LED, switch and systick registers.
module dmem_periph_responder
  import dmem_periph_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [SW_W-1:0]   switch,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [IDX_W-1:0]  ram_idx_c;
  logic              ram_hit_c;
  logic              periph_hit_c;
  logic [3:0]        off_c;
  logic              ram_we_c;
  logic              th_we_c, tl_we_c, tcon_we_c, led_we_c;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] systick_q, systick_d;
  logic [DATA_W-1:0] th_c, tl_c;
  logic [TCON_W-1:0] tcon_c;
  logic              unused_c;

  // Byte lane bits are meaningless for word-only accesses
  assign unused_c = ^addr[1:0];

  // Address decode and write strobes
  always_comb begin
    ram_hit_c    = (addr[31:IDX_W+2] == '0);
    ram_idx_c    = addr[IDX_W+1:2];
    periph_hit_c = (addr[31:6] == PERIPH_BASE[31:6]);
    off_c        = addr[5:2];
    ram_we_c     = mem_wr && ram_hit_c;
    th_we_c      = mem_wr && periph_hit_c && (off_c == OFF_TH[5:2]);
    tl_we_c      = mem_wr && periph_hit_c && (off_c == OFF_TL[5:2]);
    tcon_we_c    = mem_wr && periph_hit_c && (off_c == OFF_TCON[5:2]);
    led_we_c     = mem_wr && periph_hit_c && (off_c == OFF_LED[5:2]);
  end

  // Data RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_q[ram_idx_c] <= wdata;
    end
  end

  // LED and systick next state
  always_comb begin
    led_d     = led_q;
    systick_d = systick_q + DATA_W'(1);
    if (led_we_c) begin
      led_d = wdata[LED_W-1:0];
    end
  end

  // LED and systick registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      systick_q <= '0;
    end else begin
      led_q     <= led_d;
      systick_q <= systick_d;
    end
  end

  dmem_timer u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .th_we   (th_we_c),
    .tl_we   (tl_we_c),
    .tcon_we (tcon_we_c),
    .wdata   (wdata),
    .th      (th_c),
    .tl      (tl_c),
    .tcon    (tcon_c),
    .irq     (irq)
  );

  // Combinational read mux so MEM/WB captures load data at the end of MEM
  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      if (ram_hit_c) begin
        rdata = ram_q[ram_idx_c];
      end else if (periph_hit_c) begin
        case (off_c)
          OFF_TH[5:2]:      rdata = th_c;
          OFF_TL[5:2]:      rdata = tl_c;
          OFF_TCON[5:2]:    rdata = {(DATA_W-TCON_W)'(0), tcon_c};
          OFF_LED[5:2]:     rdata = {(DATA_W-LED_W)'(0), led_q};
          OFF_SWITCH[5:2]:  rdata = {(DATA_W-SW_W)'(0), switch};
          OFF_SYSTICK[5:2]: rdata = systick_q;
          default:          rdata = '0;
        endcase
      end
    end
  end

  assign led = led_q;

endmodule
